count_display_driver: RTL
=========================

Name: count_display_driver

Overview:
- Downstream consumer of the 4-bit free-running counter.
- Converts the counter value (0–15) to two decimal digits and drives a time-multiplexed two-digit seven-segment display.
- Contains a per-digit refresh timer, a blanking gap between digits for anti-ghosting, and a once-per-frame snapshot so the two digits never show values from different counts.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit is lit; must be ≥1.
- BLANK_CYCLES, 16: clk cycles of all-anodes-off gap after each digit; must be ≥1.
- ACTIVE_LOW, 1: 1 = seg_o/dp_o/an_o asserted low; 0 = asserted high.
- WRAP_HOLD_FRAMES, 64: frames dp_o stays lit after a wrap. Only used with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- count_i  in  4  counter value, unsigned 0–15.
- seg_o  out  7  segments {g,f,e,d,c,b,a}.
- dp_o  out  1  decimal point.
- an_o  out  2  digit enables: [0] = units, [1] = tens.
- frame_o  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset: rst_i is asynchronous, active-low; clock is clk. While rst_i=0:
  - seg_o, dp_o and an_o are all inactive (all 1s when ACTIVE_LOW=1).
  - frame_o=0, in_q=0, snap=0, timer=0, state=S_GAP_T.
- Input stage: count_i is registered into in_q every cycle (1-cycle input latency).
- FSM, cyclic: S_UNITS -> S_GAP_U -> S_TENS -> S_GAP_T -> S_UNITS.
  - S_UNITS and S_TENS last REFRESH_DIV cycles each.
  - S_GAP_U and S_GAP_T last BLANK_CYCLES cycles each.
  - timer counts 0..N-1; the state advances on timer==N-1, and timer clears on every transition.
- Snapshot: on the S_GAP_T -> S_UNITS transition, snap <= in_q and frame_o pulses for that one cycle. snap is constant for the rest of the frame.
- Frame length: 2*REFRESH_DIV + 2*BLANK_CYCLES cycles.
- Worst-case latency from a count_i change to the display: 1 + frame length cycles.
- BCD conversion:
  - tens = (snap ≥ 10).
  - units = snap − 10*tens, computed 4-bit with no overflow possible.
- Digit decode, active-high patterns before polarity: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Inverted when ACTIVE_LOW=1.
- Outputs are registered and updated on the same edge as the state transition:
  - S_UNITS: an_o[0] active, seg_o = units pattern.
  - S_TENS:
    - If tens=1: an_o[1] active, seg_o = pattern for "1".
    - If tens=0: leading-zero blanking; an_o and seg_o all inactive.
  - Gap states: an_o and seg_o all inactive. Exactly one anode is active at any time, or none.
- Mid-frame count_i changes: update in_q only; they are never visible until the next snapshot.
- Reset mid-frame: outputs go inactive immediately. After release, the first edge counts BLANK_CYCLES in S_GAP_T, then S_UNITS shows in_q captured at that edge.
- Input values are always in range; no illegal-value handling.

Optional Feature:
- Macro COUNT_DISPLAY_WRAP_DP_EN.
- Defined:
  - Wrap detect = previous in_q==15 and current in_q==0.
  - A wrap loads hold_cnt = WRAP_HOLD_FRAMES.
  - hold_cnt decrements on each frame_o pulse, saturating at 0.
  - dp_o is active during S_UNITS while hold_cnt≠0.
  - A wrap during an active hold reloads the counter.
  - A wrap on the same cycle as frame_o: the reload wins.
- Undefined: no wrap logic; dp_o is tied inactive.

Decomposition:
- Package count_display_pkg:
  - state enum (S_UNITS, S_GAP_U, S_TENS, S_GAP_T);
  - SEG_PATTERN constant array for digits 0–9;
  - SEG_OFF constant;
  - digit-index constants UNITS_IDX=0, TENS_IDX=1.
- One sub-module, hex_to_seg7: combinational 4-bit digit -> 7-bit active-high pattern; the polarity inversion stays in the top level.

Test Plan (REFRESH_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1, WRAP_HOLD_FRAMES=2):
- Reset held, count_i=7 -> seg_o=7F, an_o=3, dp_o=1, frame_o=0. Release -> frame_o pulse after 1 gap cycle; S_UNITS shows seg_o=~07=78, an_o=2 for 4 cycles.
- count_i=13 steady -> per 10-cycle frame:
  - units: seg_o=~4F=30, an_o=2, 4 cycles;
  - gap: an_o=3, 1 cycle;
  - tens: seg_o=~06=79, an_o=1, 4 cycles;
  - gap: an_o=3, 1 cycle.
- count_i=5 -> tens slot shows an_o=3, seg_o=7F (leading-zero blanking).
- count_i changes 9 -> 12 in the middle of the S_UNITS slot -> that frame shows units 9, tens blank. The next frame shows 2 / 1. A check across all cycles confirms the tens and units slots of each frame come from the same count.
- With COUNT_DISPLAY_WRAP_DP_EN, count_i 15 -> 0 -> dp_o=0 in S_UNITS for the next 2 frames, then 1. Without the macro, dp_o=1 always.
- Assert rst_i=0 mid S_TENS -> outputs inactive within the same cycle (asynchronous). Release -> the sequence restarts as in scenario 1.

Source files
------------

// File: rtl/count_display_pkg.sv
// count_display_pkg: shared FSM states, seven-segment patterns and digit indices for the display driver.
package count_display_pkg;
    typedef enum logic [1:0] {S_UNITS, S_GAP_U, S_TENS, S_GAP_T} state_e;
    localparam logic [9:0][6:0] SEG_PATTERN = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam int UNITS_IDX = 0;
    localparam int TENS_IDX = 1;
endpackage

// File: rtl/count_display_driver_hex_to_seg7.sv
// hex_to_seg7: decimal digit to active-high {g,f,e,d,c,b,a} pattern, blank for non-decimal codes.
module hex_to_seg7
    import count_display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);
    assign seg_o = (digit_i <= 4'd9) ? SEG_PATTERN[digit_i] : SEG_OFF;
endmodule

// File: rtl/count_display_driver.sv
// count_display_driver: two-digit multiplexed 7-seg driver with per-frame snapshot; COUNT_DISPLAY_WRAP_DP_EN lights dp after a 15->0 wrap.
module count_display_driver
    import count_display_pkg::*;
#(
    parameter int REFRESH_DIV      = 50000,
    parameter int BLANK_CYCLES     = 16,
    parameter int ACTIVE_LOW       = 1,
    parameter int WRAP_HOLD_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic [3:0] count_i,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [1:0] an_o,
    output logic       frame_o
);
    localparam int TMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int TW = ($clog2(TMAX) > 0) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] REF_LAST = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] BLK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [6:0] SEG_MASK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_MASK = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
    localparam logic DP_MASK = (ACTIVE_LOW != 0);

    if (REFRESH_DIV < 1 || BLANK_CYCLES < 1 || WRAP_HOLD_FRAMES < 1) begin : g_bad_params
        $error("count_display_driver: REFRESH_DIV, BLANK_CYCLES and WRAP_HOLD_FRAMES must be >= 1");
    end

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    in_q, snap_q, snap_d;
    logic          run_q;
    logic          frame_q, frame_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          dp_q, dp_d;
    logic          adv, tens, dp_act;
    logic [3:0]    units, digit;
    logic [6:0]    pat;
    logic [1:0]    an_act;

    hex_to_seg7 u_dec (.digit_i(digit), .seg_o(pat));

    // run_q delays the first count by one edge so the first snapshot sees a real in_q
    always_comb begin
        adv = run_q && timer_q == ((state_q == S_UNITS || state_q == S_TENS) ? REF_LAST : BLK_LAST);
        state_d = !adv ? state_q :
                  state_q == S_UNITS ? S_GAP_U :
                  state_q == S_GAP_U ? S_TENS :
                  state_q == S_TENS  ? S_GAP_T : S_UNITS;
        timer_d = adv ? '0 : run_q ? timer_q + 1'b1 : timer_q;
        frame_d = adv && state_q == S_GAP_T;
        snap_d = frame_d ? in_q : snap_q;
        tens = snap_d >= 4'd10;
        units = tens ? snap_d - 4'd10 : snap_d;
        digit = (state_d == S_TENS) ? {3'b000, tens} : units;
        an_act = 2'b00;
        an_act[UNITS_IDX] = state_d == S_UNITS;
        an_act[TENS_IDX] = state_d == S_TENS && tens;
        an_d = an_act ^ AN_MASK;
        seg_d = (an_act != 2'b00) ? pat ^ SEG_MASK : SEG_MASK;
        dp_d = dp_act ^ DP_MASK;
    end

`ifdef COUNT_DISPLAY_WRAP_DP_EN
    localparam int HW = ($clog2(WRAP_HOLD_FRAMES + 1) > 0) ? $clog2(WRAP_HOLD_FRAMES + 1) : 1;
    logic [3:0]    prev_q;
    logic [HW-1:0] hold_q, hold_d;

    // a fresh wrap reloads even on the frame pulse that would otherwise decrement
    always_comb begin
        hold_d = (prev_q == 4'd15 && in_q == 4'd0) ? HW'(WRAP_HOLD_FRAMES) :
                 (frame_q && hold_q != '0) ? hold_q - 1'b1 : hold_q;
        dp_act = state_d == S_UNITS && hold_q != '0;
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            prev_q <= '0;
            hold_q <= '0;
        end else begin
            prev_q <= in_q;
            hold_q <= hold_d;
        end
    end
`else
    assign dp_act = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_GAP_T;
            timer_q <= '0;
            in_q    <= '0;
            snap_q  <= '0;
            run_q   <= 1'b0;
            frame_q <= 1'b0;
            seg_q   <= SEG_MASK;
            an_q    <= AN_MASK;
            dp_q    <= DP_MASK;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            in_q    <= count_i;
            snap_q  <= snap_d;
            run_q   <= 1'b1;
            frame_q <= frame_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign seg_o   = seg_q;
    assign an_o    = an_q;
    assign dp_o    = dp_q;
    assign frame_o = frame_q;
endmodule
